// File: rtl/rfphoenix_insn_dequeue_if.sv
// rfphoenix_insn_dequeue_if
// Bundles the FIFO-side read interface, the issue-side valid/ready stream,
// the flush request and the status outputs of the instruction dequeue stage.
//   master : the dequeue stage itself
//   slave  : its environment (FIFO, issue stage, pipeline control)
interface rfphoenix_insn_dequeue_if #(
    parameter int DW   = 128,
    parameter int CNTW = 32
);
    // FIFO side (xpm std read mode, read latency 1)
    logic            fifo_empty;
    logic            fifo_rd;
    logic [DW-1:0]   fifo_dout;
    logic            fifo_v;

    // Pipeline control
    logic            flush;

    // Issue side stream
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;

    // Status
    logic            err;
    logic [CNTW-1:0] stall_cnt;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  fifo_v,
        input  flush,
        input  out_ready,
        output fifo_rd,
        output out_valid,
        output out_data,
        output err,
        output stall_cnt
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output fifo_v,
        output flush,
        output out_ready,
        input  fifo_rd,
        input  out_valid,
        input  out_data,
        input  err,
        input  stall_cnt
    );
endinterface

// File: rtl/rfphoenix_insn_dequeue.sv
// rfphoenix_insn_dequeue
// Drain stage behind the instruction FIFO. Turns the FIFO rd_en/data_valid
// handshake into a valid/ready stream through a two-entry skid queue, so the
// one-cycle read latency is hidden and one word per cycle can be sustained.
// A flush discards held words and any word returning from an earlier read.
// 'err' is a sticky flag raised when the FIFO returns data nobody asked for.
//
// Optional feature, enabled by defining RFPHOENIX_DEQ_STALL_CNT_EN:
//   stall_cnt counts cycles where a word is offered but not accepted
//   (saturating, cleared only by reset). Without the macro it is tied to 0.
//
// Reset 'rst' is asynchronous and active low.
module rfphoenix_insn_dequeue #(
    parameter int DW   = 128,
    parameter int CNTW = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    rfphoenix_insn_dequeue_if.master   bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DW-1:0] q_q [2];   // skid queue, q_q[0] is the head
    logic [DW-1:0] q_d [2];
    logic [1:0]    qc_q;      // queue occupancy, 0..2
    logic [1:0]    qc_d;
    logic          pend_q;    // a FIFO read was issued last cycle
    logic          pend_d;
    logic          err_q;
    logic          err_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic          out_valid;
    logic          pop;
    logic          push;
    logic          fifo_rd;
    logic [2:0]    occ_after;  // words held or in flight after this cycle's pop
    logic          tail_idx;   // queue slot the returning word is written to

    assign out_valid = (qc_q != 2'd0);

    // Decide pop/push and whether another FIFO read fits behind what is held
    // and in flight. Reading only when the queue will still have room for
    // the returning word keeps qc + pend <= 2, so a push never overflows.
    // NOTE: every signal of a combinational block gets a value on every path
    // (here by unconditional assignment, elsewhere by defaults first) so no
    // latch is inferred.
    always_comb begin
        pop       = out_valid & bus.out_ready & ~bus.flush;
        push      = pend_q & bus.fifo_v & ~bus.flush;
        occ_after = {1'b0, qc_q} + {2'b00, pend_q} - {2'b00, pop};
        fifo_rd   = rst & ~bus.fifo_empty & ~bus.flush & (occ_after < 3'd2);
        // Tail is qc - pop; with a push pending it is always 0 or 1.
        tail_idx  = pop ? (qc_q == 2'd2) : (qc_q == 2'd1);
    end

    // Next-state for the queue, occupancy, read tracking and error flag
    always_comb begin
        q_d[0] = q_q[0];
        q_d[1] = q_q[1];
        qc_d   = qc_q;
        pend_d = fifo_rd;
        err_d  = err_q | (bus.fifo_v & ~pend_q);

        if (bus.flush) begin
            // Flush wins over push and pop; stale words stay in the slots
            // but are invisible once the occupancy is zero.
            qc_d = 2'd0;
        end else begin
            if (pop) begin
                q_d[0] = q_q[1];
            end
            if (push) begin
                q_d[tail_idx] = bus.fifo_dout;
            end
            qc_d = qc_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // State registers with asynchronous active-low reset
    // NOTE: sequential state is assigned with non-blocking '<=' so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the two queue slots are reset because out_data must read
            // zero during reset; a deeper storage array would be left unreset
            // and qualified by the occupancy instead.
            q_q[0] <= '0;
            q_q[1] <= '0;
            qc_q   <= 2'd0;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q[0] <= q_d[0];
            q_q[1] <= q_d[1];
            qc_q   <= qc_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional stall counter
    // ------------------------------------------------------------------
`ifdef RFPHOENIX_DEQ_STALL_CNT_EN
    logic [CNTW-1:0] stall_cnt_q;
    logic [CNTW-1:0] stall_cnt_d;

    // Count offered-but-not-accepted cycles, saturating at all ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !bus.out_ready && !bus.flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs: all registered except the read enable
    // ------------------------------------------------------------------
    assign bus.fifo_rd   = fifo_rd;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = q_q[0];
    assign bus.err       = err_q;

endmodule

// File: tb/tb_rfphoenix_insn_dequeue.sv
// tb_rfphoenix_insn_dequeue
// Drives the dequeue stage from a behavioural FIFO (read latency 1) and
// compares every cycle against a queue-based reference of the skid queue.
// Honors RFPHOENIX_DEQ_STALL_CNT_EN for the expected stall counter.
module tb_rfphoenix_insn_dequeue;

    localparam int DW   = 128;
    localparam int CNTW = 32;

    typedef logic [DW-1:0] word_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    rfphoenix_insn_dequeue_if #(.DW(DW), .CNTW(CNTW)) bus ();

    rfphoenix_insn_dequeue #(.DW(DW), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural FIFO: stored words plus the word returning next cycle
    word_t fifo_q[$];
    bit    infl_v = 1'b0;
    word_t infl_d = '0;

    // Reference model of the stage
    word_t           held[$];     // words held by the stage, head first
    bit              m_pend = 1'b0;
    bit              m_err  = 1'b0;
    logic [CNTW-1:0] m_stall = '0;

    // Observations
    word_t got[$];                // words accepted by the issue side
    int    rd_count = 0;
    bit    saw44 = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic word_t rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [CNTW-1:0] exp_stall();
`ifdef RFPHOENIX_DEQ_STALL_CNT_EN
        return m_stall;
`else
        return '0;
`endif
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic cyc(input bit rdy, input bit fl, input bit inj);
        bit    exp_rd;
        bit    pop;
        bit    push;
        bit    rd_seen;
        bit    v_in;
        word_t d_in;
        int    occ;

        v_in           = infl_v || inj;
        d_in           = infl_v ? infl_d : rnd_word();
        bus.out_ready  = rdy;
        bus.flush      = fl;
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.fifo_v     = v_in;
        bus.fifo_dout  = d_in;
        #1;

        pop    = (held.size() != 0) && rdy && !fl;
        occ    = held.size() + int'(m_pend) - int'(pop);
        exp_rd = rst && (fifo_q.size() != 0) && !fl && (occ < 2);

        check("fifo_rd",   bus.fifo_rd,   exp_rd);
        check("out_valid", bus.out_valid, held.size() != 0);
        if (held.size() != 0) check("out_data", bus.out_data, held[0]);
        check("err",       bus.err,       m_err);
        check("stall_cnt", bus.stall_cnt, exp_stall());

        if (bus.out_valid && bus.out_data == word_t'('h44)) saw44 = 1'b1;
        if (bus.out_valid && rdy && !fl) got.push_back(bus.out_data);
        rd_seen = bus.fifo_rd;

        // Reference update for the coming edge
        push = m_pend && v_in && !fl;
        if (v_in && !m_pend) m_err = 1'b1;
        if ((held.size() != 0) && !rdy && !fl && (m_stall != '1)) m_stall++;
        if (fl) begin
            held.delete();
        end else begin
            if (pop)  void'(held.pop_front());
            if (push) held.push_back(d_in);
        end
        assert (held.size() <= 2) else $error("push into a full queue");
        m_pend = exp_rd;

        @(posedge clk);
        infl_v = rd_seen;
        if (rd_seen) begin
            rd_count++;
            infl_d = (fifo_q.size() != 0) ? fifo_q.pop_front() : rnd_word();
        end
        @(negedge clk);
    endtask

    // Hold reset across one rising edge with the FIFO claiming data.
    // A read in flight before reset comes back afterwards as unrequested data.
    task automatic do_reset();
        rst            = 1'b0;
        bus.fifo_empty = 1'b0;
        bus.fifo_v     = 1'b0;
        bus.fifo_dout  = '0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b1;
        #1;
        check("rst_fifo_rd",   bus.fifo_rd,   1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data",  bus.out_data,  '0);
        check("rst_err",       bus.err,       1'b0);
        check("rst_stall_cnt", bus.stall_cnt, '0);
        held.delete();
        m_pend  = 1'b0;
        m_err   = 1'b0;
        m_stall = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        word_t exp5[$];

        // Reset state
        do_reset();

        // Streaming: three words back to back with the issue side ready
        fifo_q = '{word_t'('h11), word_t'('h22), word_t'('h33)};
        got.delete();
        repeat (6) cyc(1'b1, 1'b0, 1'b0);
        check("stream_count", got.size(), 3);
        if (got.size() == 3) begin
            check("stream_w0", got[0], word_t'('h11));
            check("stream_w1", got[1], word_t'('h22));
            check("stream_w2", got[2], word_t'('h33));
        end

        // Backpressure: only two reads while the issue side stalls
        exp5 = '{word_t'('h101), word_t'('h102), word_t'('h103), word_t'('h104), word_t'('h105)};
        fifo_q = exp5;
        rd_count = 0;
        got.delete();
        repeat (6) cyc(1'b0, 1'b0, 1'b0);
        check("bp_reads", rd_count, 2);
        repeat (10) cyc(1'b1, 1'b0, 1'b0);
        check("bp_count", got.size(), 5);
        foreach (exp5[i]) begin
            if (i < got.size()) check("bp_order", got[i], exp5[i]);
        end

        // Flush in the cycle the word 0x44 returns from the FIFO
        fifo_q = '{word_t'('h41), word_t'('h42), word_t'('h44), word_t'('h45)};
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        check("flush_setup", infl_d, word_t'('h44));
        cyc(1'b1, 1'b1, 1'b0);
        #1;
        check("flush_empty", bus.out_valid, 1'b0);
        repeat (5) cyc(1'b1, 1'b0, 1'b0);

        // Protocol error: data_valid with no read outstanding, one word held
        fifo_q = '{word_t'('h55)};
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        #1;
        check("err_set",       bus.err,       1'b1);
        check("err_qc_valid",  bus.out_valid, 1'b1);
        check("err_qc_data",   bus.out_data,  word_t'('h55));
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        check("err_sticky",    bus.err,       1'b1);

        // Stall counter: seven offered-but-not-accepted cycles after reset
        do_reset();
        fifo_q = '{word_t'('h66)};
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        repeat (7) cyc(1'b0, 1'b0, 1'b0);
        #1;
`ifdef RFPHOENIX_DEQ_STALL_CNT_EN
        check("stall_7", bus.stall_cnt, 7);
`else
        check("stall_7", bus.stall_cnt, 0);
`endif
        repeat (2) cyc(1'b1, 1'b0, 1'b0);

        // Randomized traffic with sporadic flushes and a mid-stream reset
        for (int i = 0; i < 400; i++) begin
            if (fifo_q.size() < 3 && $urandom_range(0, 1) == 0) fifo_q.push_back(rnd_word());
            if (i == 200) begin
                // Make sure a read is likely in flight when reset hits
                fifo_q.push_back(rnd_word());
                cyc(1'b1, 1'b0, 1'b0);
                do_reset();
            end
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 1'b0);
        end

        check("no_44", saw44, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
